if_fetch_unit: RTL

- Instruction-fetch stage that sits between the PC register and decode.
- Reads the current PC and drives `o_next_pc` back into the PC register.
- Issues in-order requests to instruction memory and buffers returned words with their PCs in a DEPTH-entry reorder-free queue.
- Presents instructions to decode through a valid/ready handshake; handles redirects (branch/jump/exception) by flushing and dropping stale in-flight responses.

---
 rtl/if_fetch_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests, buffers returned words
// with their PCs, and drops stale responses after a redirect. IF_FETCH_PERF_EN adds perf counters.
module if_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    output logic [31:0] o_next_pc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    input  logic        i_id_ready,
    output logic [31:0] o_perf_fetched,
    output logic [31:0] o_perf_bubbles
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_P = DEPTH[AW:0];
    localparam logic [AW:0] ONE     = 1;

    logic [AW:0] alloc_ptr;
    logic [AW:0] fill_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] drop_cnt;
    logic [AW:0] used;
    logic [AW:0] unfilled;
    logic [AW:0] rvalid_ext;
    logic        grant;
    logic        fire;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    assign used       = alloc_ptr - rd_ptr;
    assign unfilled   = alloc_ptr - fill_ptr;
    assign rvalid_ext = {{AW{1'b0}}, i_imem_rvalid};

    // Requests stall while stale responses are still owed from before a redirect.
    assign o_imem_req  = !i_rst && !i_redirect && (used < DEPTH_P) && (drop_cnt == '0);
    assign o_imem_addr = i_pc;
    assign grant       = o_imem_req && i_imem_gnt;

    assign o_if_valid = (fill_ptr != rd_ptr) && !i_redirect && !i_rst;
    assign fire       = o_if_valid && i_id_ready;
    assign o_if_instr = instr_mem[rd_ptr[AW-1:0]];
    assign o_if_pc    = pc_mem[rd_ptr[AW-1:0]];

    always_comb begin
        // NOTE: default assignment first so every path drives o_next_pc and no latch is inferred.
        o_next_pc = i_pc;
        if (i_rst) begin
            o_next_pc = RESET_PC;
        end else if (i_redirect) begin
            o_next_pc = i_redirect_pc;
        end else if (grant) begin
            o_next_pc = i_pc + 32'd4;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all pointers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
        end else if (i_redirect) begin
            // A response in this cycle always belongs to the flushed stream.
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= drop_cnt + unfilled - rvalid_ext;
        end else begin
            if (grant) begin
                alloc_ptr <= alloc_ptr + ONE;
            end
            if (i_imem_rvalid) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - ONE;
                end else begin
                    fill_ptr <= fill_ptr + ONE;
                end
            end
            if (fire) begin
                rd_ptr <= rd_ptr + ONE;
            end
        end
    end

    // NOTE: buffer storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge i_clk) begin
        if (grant) begin
            pc_mem[alloc_ptr[AW-1:0]] <= i_pc;
        end
        if (!i_rst && !i_redirect && i_imem_rvalid && (drop_cnt == '0)) begin
            instr_mem[fill_ptr[AW-1:0]] <= i_imem_rdata;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (fire) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (!o_if_valid && i_id_ready) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end

    assign o_perf_fetched = perf_fetched;
    assign o_perf_bubbles = perf_bubbles;
`else
    assign o_perf_fetched = 32'd0;
    assign o_perf_bubbles = 32'd0;
`endif

    // Every response must belong to either a buffered request or a stale one being dropped.
    rsp_has_owner: assert property (@(posedge i_clk) disable iff (i_rst)
        i_imem_rvalid |-> ((unfilled != '0) || (drop_cnt != '0)));

endmodule
